// File: rtl/mrd_fsm_pkt.sv
// Shared definitions for the mixed-radix DFT memory-core sequencer:
// state codes seen by FSMrd / FSMsource and the stage-count helper.
package mrd_fsm_pkt;

    typedef logic [2:0] fsm_t;

    localparam fsm_t FSM_IDLE     = 3'd0;
    localparam fsm_t FSM_SINK     = 3'd1;
    localparam fsm_t FSM_WAIT_RD  = 3'd2;
    localparam fsm_t FSM_RD       = 3'd3;
    localparam fsm_t FSM_WAIT_WR  = 3'd4;
    localparam fsm_t FSM_SOURCE   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = FSM_IDLE,
        ST_SINK    = FSM_SINK,
        ST_WAIT_RD = FSM_WAIT_RD,
        ST_RD      = FSM_RD,
        ST_WAIT_WR = FSM_WAIT_WR,
        ST_SOURCE  = FSM_SOURCE
    } state_e;

    // Number of leading nonzero radix entries; the first zero ends the list.
    function automatic logic [2:0] count_stages(input logic [0:5][2:0] nf);
        logic [2:0] n;
        logic       run;
        n   = 3'd0;
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (run && (nf[i] != 3'd0)) begin
                n = n + 3'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mrd_fsm_watchdog.sv
// Progress watchdog: counts cycles since the last clear while enabled and
// flags the cycle in which the window reaches TIMEOUT cycles.
module mrd_fsm_watchdog
    import mrd_fsm_pkt::*;
#(
    parameter int TIMEOUT = 16384,
    parameter int TO_W    = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TO_W-1:0] cnt;

    // The clearing cycle itself counts as the first cycle of a new window,
    // so expire fires in the TIMEOUT-th cycle without progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= TO_W'(1);
        end else begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign expire = enable & ~clear & (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mrd_fsm_ctrl.sv
// Top-level frame sequencer: sink one frame, run one read/write pass per
// radix stage, stream the last stage out. Checks frame length, flags
// overflow and aborts to Idle when no progress is seen for TIMEOUT cycles.
//
// Sink handshake: a sample is accepted in a cycle where sink_valid and
// sink_ready are both high; sink_valid while sink_ready is low drops the
// sample and pulses err_ovf. sink_ready does not depend on sink_valid.
module mrd_fsm_ctrl
    import mrd_fsm_pkt::*;
#(
    parameter int WAIT_RD = 8,
    parameter int TIMEOUT = 16384,
    parameter int TO_W    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sink_valid,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic [11:0]      dftpts,
    input  logic [0:5][2:0]  Nf,
    input  logic             rd_stage_done,
    input  logic             wr_stage_done,
    input  logic             source_end,
    output logic [2:0]       fsm,
    output logic [2:0]       fsm_r,
    output logic             fsm_lastRd_source,
    output logic [2:0]       stage_cnt,
    output logic             rd_start,
    output logic             sink_ready,
    output logic             err_len,
    output logic             err_ovf,
    output logic             err_timeout
);

    localparam int WW = (WAIT_RD > 1) ? $clog2(WAIT_RD) : 1;

    state_e          state;
    logic [11:0]     cnt;
    logic [11:0]     dftpts_l;
    logic [2:0]      nst_l;
    logic            pending;
    logic [WW-1:0]   wait_cnt;

    logic            accept;
    logic [2:0]      nf_stages;
    logic [11:0]     cnt_sat;
    logic            len_bad;
    logic            last_stage;
    logic [2:0]      next_stage;
    logic            next_is_last;
    logic            wd_clear;
    logic            wd_enable;
    logic            wd_expire;

    assign fsm          = state;
    assign accept       = sink_valid & sink_ready;
    assign nf_stages    = count_stages(Nf);
    assign cnt_sat      = (cnt == 12'hFFF) ? cnt : cnt + 12'd1;
    // 13-bit compare so a saturated count never aliases a valid length.
    assign len_bad      = (({1'b0, cnt} + 13'd1) != {1'b0, dftpts_l});
    assign last_stage   = (stage_cnt == (nst_l - 3'd1));
    assign next_stage   = stage_cnt + 3'd1;
    assign next_is_last = (next_stage == (nst_l - 3'd1));

    assign wd_clear  = (fsm != fsm_r) | rd_stage_done | wr_stage_done | sink_valid;
    assign wd_enable = (state != ST_IDLE);

    mrd_fsm_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Main sequencer: state, stage tracking, sink counting and error flags.
    // fsm_r is a plain delay of fsm, so after a reset it settles one cycle
    // behind fsm.
    always_ff @(posedge clk) begin
        fsm_r <= fsm;
        if (!rst_n) begin
            state             <= ST_IDLE;
            fsm_lastRd_source <= 1'b0;
            stage_cnt         <= 3'd0;
            rd_start          <= 1'b0;
            sink_ready        <= 1'b0;
            err_len           <= 1'b0;
            err_ovf           <= 1'b0;
            err_timeout       <= 1'b0;
            cnt               <= 12'd0;
            dftpts_l          <= 12'd0;
            nst_l             <= 3'd0;
            pending           <= 1'b0;
            wait_cnt          <= '0;
        end else begin
            rd_start    <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= sink_valid & ~sink_ready;
            // Staying put keeps sink_ready tied to Idle/Sink; transitions override.
            sink_ready  <= (state == ST_IDLE) || (state == ST_SINK);

            if (wd_expire) begin
                state             <= ST_IDLE;
                err_timeout       <= 1'b1;
                fsm_lastRd_source <= 1'b0;
                stage_cnt         <= 3'd0;
                pending           <= 1'b0;
                sink_ready        <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept && sink_sop && (nf_stages != 3'd0)) begin
                            dftpts_l <= dftpts;
                            nst_l    <= nf_stages;
                            cnt      <= 12'd1;
                            if (sink_eop) begin
                                state      <= ST_WAIT_RD;
                                wait_cnt   <= '0;
                                sink_ready <= 1'b0;
                                err_len    <= (dftpts != 12'd1);
                            end else begin
                                state   <= ST_SINK;
                                err_len <= 1'b0;
                            end
                        end
                    end

                    ST_SINK: begin
                        if (accept) begin
                            if (sink_sop) begin
                                // Restart of a frame mid-sink: count anew, flag it.
                                cnt      <= 12'd1;
                                err_len  <= 1'b1;
                                dftpts_l <= dftpts;
                                if (nf_stages != 3'd0) begin
                                    nst_l <= nf_stages;
                                end
                            end else begin
                                cnt <= cnt_sat;
                            end
                            if (sink_eop) begin
                                state      <= ST_WAIT_RD;
                                wait_cnt   <= '0;
                                sink_ready <= 1'b0;
                                if (!sink_sop) begin
                                    err_len <= err_len | len_bad;
                                end
                            end
                        end
                    end

                    ST_WAIT_RD: begin
                        if (wait_cnt == WW'(WAIT_RD - 1)) begin
                            state             <= ST_RD;
                            stage_cnt         <= 3'd0;
                            rd_start          <= 1'b1;
                            pending           <= 1'b0;
                            fsm_lastRd_source <= (nst_l == 3'd1);
                        end else begin
                            wait_cnt <= wait_cnt + WW'(1);
                        end
                    end

                    ST_RD: begin
                        if (wr_stage_done) begin
                            pending <= 1'b1;
                        end
                        if (rd_stage_done) begin
                            state <= last_stage ? ST_SOURCE : ST_WAIT_WR;
                        end
                    end

                    ST_WAIT_WR: begin
                        if (wr_stage_done || pending) begin
                            state             <= ST_RD;
                            stage_cnt         <= next_stage;
                            pending           <= 1'b0;
                            rd_start          <= 1'b1;
                            fsm_lastRd_source <= next_is_last;
                        end
                    end

                    ST_SOURCE: begin
                        if (source_end) begin
                            state             <= ST_IDLE;
                            fsm_lastRd_source <= 1'b0;
                            stage_cnt         <= 3'd0;
                            pending           <= 1'b0;
                            sink_ready        <= 1'b1;
                        end
                    end

                    default: begin
                        state             <= ST_IDLE;
                        fsm_lastRd_source <= 1'b0;
                        stage_cnt         <= 3'd0;
                        pending           <= 1'b0;
                        sink_ready        <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mrd_fsm_ctrl.sv
// Bench for mrd_fsm_ctrl: directed frames, expected output events queued
// by the stimulus side and checked by an independent negedge monitor.
module tb_mrd_fsm_ctrl;

    localparam int W = 20;

    logic             clk;
    logic             rst_n;
    logic             sink_valid;
    logic             sink_sop;
    logic             sink_eop;
    logic [11:0]      dftpts;
    logic [0:5][2:0]  nf;
    logic             rd_stage_done;
    logic             wr_stage_done;
    logic             source_end;
    logic [2:0]       fsm;
    logic [2:0]       fsm_r;
    logic             fsm_lastRd_source;
    logic [2:0]       stage_cnt;
    logic             rd_start;
    logic             sink_ready;
    logic             err_len;
    logic             err_ovf;
    logic             err_timeout;

    int               total;
    int               bad;
    logic [W-1:0]     exp_q[$];

    logic             armed;
    logic             have_prev;
    logic [2:0]       prev_fsm;
    logic [2:0]       last_fsm;
    int               cyc;
    int               last_evt;
    logic [W-1:0]     act_r;
    logic [W-1:0]     exp_r;

    localparam logic [0:5][2:0] NF2 = {3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
    localparam logic [0:5][2:0] NF1 = {3'd5, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0};
    localparam logic [0:5][2:0] NF0 = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    mrd_fsm_ctrl #(
        .WAIT_RD (8),
        .TIMEOUT (64),
        .TO_W    (7)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sink_valid        (sink_valid),
        .sink_sop          (sink_sop),
        .sink_eop          (sink_eop),
        .dftpts            (dftpts),
        .Nf                (nf),
        .rd_stage_done     (rd_stage_done),
        .wr_stage_done     (wr_stage_done),
        .source_end        (source_end),
        .fsm               (fsm),
        .fsm_r             (fsm_r),
        .fsm_lastRd_source (fsm_lastRd_source),
        .stage_cnt         (stage_cnt),
        .rd_start          (rd_start),
        .sink_ready        (sink_ready),
        .err_len           (err_len),
        .err_ovf           (err_ovf),
        .err_timeout       (err_timeout)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event record: {gap, fsm, stage, lastRd, rd_start, sink_ready, err_len, err_ovf, err_timeout}
    // gap = cycles since the previous event; an expected gap of 0 is not checked.
    function automatic logic [W-1:0] mk(input int gap, input int f, input int st,
                                        input int lr, input int rs, input int sr,
                                        input int el, input int eo, input int et);
        return {8'(gap), 3'(f), 3'(st), 1'(lr), 1'(rs), 1'(sr), 1'(el), 1'(eo), 1'(et)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [11:0] len, input logic [0:5][2:0] nfv, input int nsamp);
        dftpts = len;
        nf     = nfv;
        for (int i = 1; i <= nsamp; i++) begin
            sink_valid = 1'b1;
            sink_sop   = (i == 1);
            sink_eop   = (i == nsamp);
            step();
        end
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic pulse(input logic v, input logic r, input logic w, input logic s);
        sink_valid    = v;
        rd_stage_done = r;
        wr_stage_done = w;
        source_end    = s;
        step();
        sink_valid    = 1'b0;
        rd_stage_done = 1'b0;
        wr_stage_done = 1'b0;
        source_end    = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Expected events of a two-stage frame with nsamp samples and err_len value l.
    task automatic push_two_stage(input int nsamp, input int l);
        exp_q.push_back(mk(0,         1, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(mk(nsamp - 1, 2, 0, 0, 0, 0, l, 0, 0));
        exp_q.push_back(mk(8,         3, 0, 0, 1, 0, l, 0, 0));
        exp_q.push_back(mk(5,         4, 0, 0, 0, 0, l, 0, 0));
        exp_q.push_back(mk(5,         3, 1, 1, 1, 0, l, 0, 0));
        exp_q.push_back(mk(5,         5, 1, 1, 0, 0, l, 0, 0));
        exp_q.push_back(mk(5,         0, 0, 0, 0, 1, l, 0, 0));
    endtask

    // rd, wr, rd, source_end, each 5 cycles apart, the first 5 cycles into Rd.
    task automatic drive_two_stage();
        idle(12);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
    endtask

    // Monitor: fsm_r delay check every cycle, event scoreboard on output activity.
    always @(negedge clk) begin
        if (armed) begin
            cyc++;
            if (have_prev) begin
                total++;
                if (fsm_r !== prev_fsm) begin
                    bad++;
                    $display("FAIL fsm_r_delay got=%0d required=%0d cyc=%0d", fsm_r, prev_fsm, cyc);
                end
            end
            prev_fsm  = fsm;
            have_prev = 1'b1;
            if ((fsm !== last_fsm) || rd_start || err_ovf || err_timeout) begin
                act_r = mk(cyc - last_evt, fsm, stage_cnt, fsm_lastRd_source, rd_start,
                           sink_ready, err_len, err_ovf, err_timeout);
                last_evt = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got gap=%0d fsm=%0d stg=%0d flags=%b cyc=%0d",
                             act_r[19:12], act_r[11:9], act_r[8:6], act_r[5:0], cyc);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (exp_r[19:12] == 8'd0) act_r[19:12] = 8'd0;
                    if (act_r !== exp_r) begin
                        bad++;
                        $display("FAIL sb_event got gap=%0d fsm=%0d stg=%0d flags=%b required gap=%0d fsm=%0d stg=%0d flags=%b cyc=%0d",
                                 act_r[19:12], act_r[11:9], act_r[8:6], act_r[5:0],
                                 exp_r[19:12], exp_r[11:9], exp_r[8:6], exp_r[5:0], cyc);
                    end
                end
            end
            last_fsm = fsm;
        end
    end

    // Stimulus
    initial begin
        total = 0; bad = 0;
        armed = 1'b0; have_prev = 1'b0;
        prev_fsm = 3'd0; last_fsm = 3'd0;
        cyc = 0; last_evt = 0;
        rst_n = 1'b0;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        dftpts = 12'd0; nf = NF0;
        rd_stage_done = 1'b0; wr_stage_done = 1'b0; source_end = 1'b0;

        // reset state
        idle(3);
        @(negedge clk);
        chk("rst_fsm", fsm, 0);
        chk("rst_lastrd", fsm_lastRd_source, 0);
        chk("rst_stage", stage_cnt, 0);
        chk("rst_rd_start", rd_start, 0);
        chk("rst_sink_ready", sink_ready, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_timeout", err_timeout, 0);
        rst_n = 1'b1;
        step();
        armed = 1'b1;
        @(negedge clk);
        chk("sink_ready_after_rst", sink_ready, 1);

        // nominal two-stage frame
        push_two_stage(12, 0);
        send_frame(12'd12, NF2, 12);
        drive_two_stage();

        // short frame: eop on 10th sample
        push_two_stage(10, 1);
        send_frame(12'd12, NF2, 10);
        drive_two_stage();
        @(negedge clk);
        chk("err_len_sticky", err_len, 1);

        // simultaneous rd/wr done in non-last Rd; sop also clears err_len
        exp_q.push_back(mk(0,  1, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(mk(11, 2, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(8,  3, 0, 0, 1, 0, 0, 0, 0));
        exp_q.push_back(mk(5,  4, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(1,  3, 1, 1, 1, 0, 0, 0, 0));
        exp_q.push_back(mk(5,  5, 1, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(5,  0, 0, 0, 0, 1, 0, 0, 0));
        send_frame(12'd12, NF2, 12);
        idle(12);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        idle(5);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // overflow: sink_valid during Rd
        exp_q.push_back(mk(0,  1, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(mk(11, 2, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(8,  3, 0, 0, 1, 0, 0, 0, 0));
        exp_q.push_back(mk(3,  3, 0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(mk(2,  4, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(5,  3, 1, 1, 1, 0, 0, 0, 0));
        exp_q.push_back(mk(5,  5, 1, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(5,  0, 0, 0, 0, 1, 0, 0, 0));
        send_frame(12'd12, NF2, 12);
        idle(10);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // timeout: no rd_stage_done, abort after 64 cycles in Rd
        exp_q.push_back(mk(0,  1, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(mk(11, 2, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(8,  3, 0, 0, 1, 0, 0, 0, 0));
        exp_q.push_back(mk(64, 0, 0, 0, 0, 1, 0, 0, 1));
        send_frame(12'd12, NF2, 12);
        idle(75);
        @(negedge clk);
        chk("to_fsm_idle", fsm, 0);
        chk("to_sink_ready", sink_ready, 1);
        chk("to_pulse_ended", err_timeout, 0);

        // degenerate: sop with all-zero Nf, and valid without sop, in Idle
        dftpts = 12'd12;
        nf = NF0;
        sink_valid = 1'b1;
        sink_sop   = 1'b1;
        step();
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        idle(2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        chk("nf0_fsm_idle", fsm, 0);
        chk("nf0_sink_ready", sink_ready, 1);

        // single-stage frame (Nf leading count 1), reset while in Source
        exp_q.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(mk(3, 2, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(8, 3, 0, 1, 1, 0, 0, 0, 0));
        exp_q.push_back(mk(5, 5, 0, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        send_frame(12'd4, NF1, 4);
        idle(12);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("rst_src_fsm_r_lags", fsm_r, 5);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("rst_src_fsm_r", fsm_r, 0);
        chk("rst_src_sink_ready", sink_ready, 1);

        idle(3);
        chk("sb_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
